// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time, a variable-latency ack handshake to the data memory,
// byte-lane steering, sign/zero extension, misalignment/illegal-size detection and an ack timeout.
module load_store_unit #(
  parameter int DataWidth     = 32,
  parameter int AddrWidth     = 32,
  parameter int TimeoutCycles = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic [2:0]             req_funct3,
  input  logic [AddrWidth-1:0]   req_addr,
  input  logic [DataWidth-1:0]   req_wdata,
  output logic                   resp_valid,
  output logic [DataWidth-1:0]   resp_rdata,
  output logic                   resp_error,
  output logic                   busy,
  output logic                   data_read,
  output logic [DataWidth/8-1:0] data_write,
  output logic [AddrWidth-1:0]   data_addr,
  output logic [DataWidth-1:0]   data_in,
  input  logic [DataWidth-1:0]   data_out,
  input  logic                   data_ack
);

  localparam int NumBytes = DataWidth / 8;
  localparam int OffWidth = $clog2(NumBytes);
  localparam int CntWidth = (TimeoutCycles > 2) ? $clog2(TimeoutCycles) : 1;
  localparam logic [CntWidth-1:0] CntLast =
    CntWidth'((TimeoutCycles > 0) ? (TimeoutCycles - 1) : 0);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic                  r_write;
  logic [2:0]            r_funct3;
  logic [AddrWidth-1:0]  r_addr;
  logic [DataWidth-1:0]  r_wdata;
  logic [CntWidth-1:0]   r_cnt;
  logic                  r_err;
  logic [DataWidth-1:0]  r_rdata;

  logic [OffWidth-1:0]   w_req_off;
  logic                  w_illegal;
  logic                  w_misaligned;
  logic                  w_req_bad;
  logic                  w_timeout;
  logic [OffWidth-1:0]   w_off;
  logic [OffWidth+2:0]   w_shamt;
  logic [DataWidth-1:0]  w_lane;
  logic [DataWidth-1:0]  w_lmask;
  logic                  w_sign;
  logic [DataWidth-1:0]  w_load_ext;
  logic [NumBytes-1:0]   w_be_mask;
  logic [DataWidth-1:0]  w_dmask;
  logic [NumBytes-1:0]   w_strobe;
  logic [DataWidth-1:0]  w_store_data;

  // Request classification, decided from the live request while IDLE
  always_comb begin
    w_req_off = req_addr[OffWidth-1:0];
    w_illegal = ((req_funct3[1:0] == 2'd3) && (DataWidth == 32)) ||
                (!req_write && (req_funct3 == 3'b111)) ||
                (req_write && req_funct3[2]);
    case (req_funct3[1:0])
      2'd0:    w_misaligned = 1'b0;
      2'd1:    w_misaligned = w_req_off[0];
      2'd2:    w_misaligned = |w_req_off[1:0];
      default: w_misaligned = |w_req_off;
    endcase
    w_req_bad = w_illegal | w_misaligned;
    w_timeout = (TimeoutCycles != 0) && (r_cnt == CntLast);
  end

  // Lane steering for stores and extraction/extension for loads, from latched request
  always_comb begin
    w_off   = r_addr[OffWidth-1:0];
    w_shamt = {w_off, 3'b000};
    w_lane  = data_out >> w_shamt;
    case (r_funct3[1:0])
      2'd0: begin
        w_lmask   = DataWidth'(64'h0000_0000_0000_00FF);
        w_sign    = w_lane[7];
        w_be_mask = NumBytes'(8'h01);
      end
      2'd1: begin
        w_lmask   = DataWidth'(64'h0000_0000_0000_FFFF);
        w_sign    = w_lane[15];
        w_be_mask = NumBytes'(8'h03);
      end
      2'd2: begin
        w_lmask   = DataWidth'(64'h0000_0000_FFFF_FFFF);
        w_sign    = w_lane[31];
        w_be_mask = NumBytes'(8'h0F);
      end
      default: begin
        w_lmask   = {DataWidth{1'b1}};
        w_sign    = w_lane[DataWidth-1];
        w_be_mask = {NumBytes{1'b1}};
      end
    endcase
    w_load_ext = (w_lane & w_lmask) | ({DataWidth{w_sign & ~r_funct3[2]}} & ~w_lmask);
    for (int i = 0; i < NumBytes; i++) begin
      w_dmask[8*i +: 8] = {8{w_be_mask[i]}};
    end
    w_strobe     = w_be_mask << w_off;
    w_store_data = (r_wdata & w_dmask) << w_shamt;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          w_next_state = w_req_bad ? ST_RESP : ST_ACCESS;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (data_ack || w_timeout) begin
          w_next_state = ST_RESP;
        end else begin
          w_next_state = ST_ACCESS;
        end
      end
      ST_RESP: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Request latch, timeout counter and response capture
  always_ff @(posedge clk) begin
    if (rst) begin
      r_write  <= 1'b0;
      r_funct3 <= 3'b000;
      r_addr   <= {AddrWidth{1'b0}};
      r_wdata  <= {DataWidth{1'b0}};
      r_cnt    <= {CntWidth{1'b0}};
      r_err    <= 1'b0;
      r_rdata  <= {DataWidth{1'b0}};
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_write  <= req_write;
            r_funct3 <= req_funct3;
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
            r_cnt    <= {CntWidth{1'b0}};
            r_err    <= w_req_bad;
            r_rdata  <= {DataWidth{1'b0}};
          end
        end
        ST_ACCESS: begin
          // An ack on the last permitted cycle takes priority over the timeout
          if (data_ack) begin
            r_err   <= 1'b0;
            r_rdata <= r_write ? {DataWidth{1'b0}} : w_load_ext;
          end else if (w_timeout) begin
            r_err   <= 1'b1;
            r_rdata <= {DataWidth{1'b0}};
          end else begin
            r_cnt   <= r_cnt + CntWidth'(1);
          end
        end
        default: begin
          r_cnt <= r_cnt;
        end
      endcase
    end
  end

  // Outputs decoded from state and latched values only
  always_comb begin
    req_ready  = (r_state == ST_IDLE);
    busy       = (r_state != ST_IDLE);
    resp_valid = 1'b0;
    resp_error = 1'b0;
    resp_rdata = {DataWidth{1'b0}};
    data_read  = 1'b0;
    data_write = {NumBytes{1'b0}};
    data_addr  = {AddrWidth{1'b0}};
    data_in    = {DataWidth{1'b0}};
    if (r_state == ST_ACCESS) begin
      data_addr = {r_addr[AddrWidth-1:OffWidth], {OffWidth{1'b0}}};
      if (r_write) begin
        data_write = w_strobe;
        data_in    = w_store_data;
      end else begin
        data_read  = 1'b1;
      end
    end else if (r_state == ST_RESP) begin
      resp_valid = 1'b1;
      resp_error = r_err;
      resp_rdata = r_rdata;
    end else begin
      resp_valid = 1'b0;
    end
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Parametrised load/store unit that replaces the purely combinational memory-access path of the single-cycle core. It accepts one load/store request at a time from the execute stage and drives the data-memory port through a variable-latency ack handshake. It supports DataWidth 32 or 64, with byte-lane steering, sign/zero extension, misalignment detection and an ack timeout. It sits between the core's execute/write-back logic and the data SRAM.

Parameters:
DataWidth, 32, memory/register data width; legal values 32 or 64.
AddrWidth, 32, byte address width.
TimeoutCycles, 255, maximum ACCESS cycles without ack before erroring; 0 disables the timeout.

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
req_valid  input  1  request present from execute stage
req_ready  output  1  unit can accept a request (IDLE only)
req_write  input  1  1=store, 0=load
req_funct3  input  3  RISC-V funct3; [1:0] size (0 B, 1 H, 2 W, 3 D); [2] unsigned load
req_addr  input  AddrWidth  byte address
req_wdata  input  DataWidth  store data, LSB-aligned
resp_valid  output  1  one-cycle completion pulse
resp_rdata  output  DataWidth  extended load data; 0 for stores and errors
resp_error  output  1  misaligned, illegal size, or timeout; valid with resp_valid
busy  output  1  state != IDLE
data_read  output  1  memory read enable
data_write  output  DataWidth/8  byte write strobes
data_addr  output  AddrWidth  word-aligned address (low log2(DataWidth/8) bits = 0)
data_in  output  DataWidth  lane-steered write data
data_out  input  DataWidth  memory read data
data_ack  input  1  memory completes access this cycle

Behaviour:
- Reset (sync, high): state=IDLE. req_ready=1 from the first cycle after reset. All other outputs 0; timeout counter 0.
- Reset mid-operation: abort the access, drop strobes at the same edge, no resp_valid.
- FSM states: IDLE, ACCESS, RESP.
- IDLE: req_ready=1. On req_valid at an edge, latch write, funct3, addr and wdata. Compute offset = addr low bits.
  - Illegal (size 3 with DataWidth=32, or funct3=111 on a load, or funct3[2]=1 on a store) or misaligned (offset not a multiple of 2^size): go to RESP with error=1. No memory strobe is ever asserted.
  - Otherwise go to ACCESS with counter=0.
- ACCESS: data_addr = latched addr with low bits cleared.
  - Load: data_read=1.
  - Store: data_write = ((1<<2^size)-1) << offset, and data_in = wdata low 2^size bytes shifted left by 8*offset (other lanes 0).
  - Strobes are held constant every cycle until exit.
  - If data_ack=1 at an edge: capture data_out and go to RESP with error=0.
  - Else increment the counter. If TimeoutCycles!=0 and counter reaches TimeoutCycles-1 at an edge with no ack: go to RESP with error=1.
  - Ack on the final timeout cycle wins (no error).
- RESP: resp_valid=1 for exactly one cycle; strobes 0.
  - Load success: resp_rdata = captured lane bits [8*offset +: 8*2^size], sign-extended (funct3[2]=0) or zero-extended to DataWidth.
  - Otherwise resp_rdata=0.
  - Next state IDLE. A new request can be accepted in the cycle after RESP.
- req_valid outside IDLE: ignored (req_ready=0); the requester holds it.
- data_ack outside ACCESS: ignored.
- Latency: accept edge T → ACCESS from T+1. Ack seen in ACCESS cycle k (k ≥ 1) → resp_valid in cycle T+k+1. Error path → resp_valid at T+1.
- All outputs are registered or decoded from state and latched values only; there is no combinational path from req_* to data_*.

Test Plan:
- LW addr 0x104, data_out=0xDEADBEEF, ack in 3rd ACCESS cycle → data_read=1 for 3 cycles, data_addr=0x104, one resp_valid, resp_rdata=0xDEADBEEF, resp_error=0.
- LB addr 0x103, data_out=0x80FF0000 → resp_rdata=0xFFFFFF80. Repeat with LBU → 0x00000080.
- SH addr 0x102, wdata=0x1234ABCD, ack in 1st cycle → data_write=4'b1100, data_in=0xABCD0000, data_addr=0x100, resp_error=0.
- LW addr 0x106; and LD (funct3=011) on DataWidth=32 → resp_valid at T+1, resp_error=1, data_read/data_write never asserted.
- TimeoutCycles=4, LW with no ack → data_read high exactly 4 cycles, then resp_valid with resp_error=1, resp_rdata=0. Second run with ack in 4th cycle → resp_error=0.
- rst asserted in 2nd ACCESS cycle of a store → data_write=0 and busy=0 after that edge, no resp_valid, req_ready=1 next cycle; DataWidth=64 LW addr 0x0C → data_write/offset lanes 4–7 selected correctly.
